// File: rtl/uart_pkg.sv
// Shared constants for the UART command-frame parser: FSM encoding, error
// codes and the default start-of-frame byte.
package uart_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LEN     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CSUM    = 2'd3;

  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] HEADER_DEF = 8'h55;

  // Running frame checksum: plain 8-bit sum, wraps modulo 256.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-in / payload-and-status-out bundle between uart_rx and the frame parser.
interface uart_frame_parser_if;

  logic [7:0] rx_data;
  logic       done_flag;
  logic [7:0] pld_data;
  logic       pld_valid;
  logic       pld_last;
  logic [7:0] frame_len;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  modport master (
    output rx_data, done_flag,
    input  pld_data, pld_valid, pld_last, frame_len, frame_ok, frame_err, err_code
  );

  modport slave (
    input  rx_data, done_flag,
    output pld_data, pld_valid, pld_last, frame_len, frame_ok, frame_err, err_code
  );

endinterface

// File: rtl/uart_frame_parser.sv
// Delimits HEADER, LEN, payload, CHECKSUM frames from a uart_rx byte stream,
// forwards payload bytes and ends every frame with one ok or error pulse.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] HEADER      = HEADER_DEF,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 100000,
  parameter int         CNT_W       = 17
) (
  input  logic              sclk_50M,
  input  logic              s_rst_n,
  uart_frame_parser_if.slave bus
);

  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state;
  logic [7:0]       byte_cnt;
  logic [7:0]       sum;
  logic [CNT_W-1:0] tmo_cnt;

  logic [7:0] pld_data;
  logic       pld_valid;
  logic       pld_last;
  logic [7:0] frame_len;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  always_ff @(posedge sclk_50M or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state     <= ST_IDLE;
      byte_cnt  <= '0;
      sum       <= '0;
      tmo_cnt   <= '0;
      pld_data  <= '0;
      pld_valid <= 1'b0;
      pld_last  <= 1'b0;
      frame_len <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
    end else begin
      pld_valid <= 1'b0;
      pld_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      // A received byte always takes priority over a timeout expiring in the same cycle.
      if (bus.done_flag) begin
        tmo_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (bus.rx_data == HEADER) state <= ST_LEN;
          end
          ST_LEN: begin
            if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
              frame_err <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= ST_IDLE;
            end else begin
              frame_len <= bus.rx_data;
              sum       <= bus.rx_data;
              byte_cnt  <= bus.rx_data;
              state     <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            pld_data  <= bus.rx_data;
            pld_valid <= 1'b1;
            sum       <= sum8(sum, bus.rx_data);
            byte_cnt  <= byte_cnt - 8'd1;
            if (byte_cnt == 8'd1) begin
              pld_last <= 1'b1;
              state    <= ST_CSUM;
            end
          end
          default: begin
            if (bus.rx_data == sum) begin
              frame_ok <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= ERR_CSUM;
            end
            state <= ST_IDLE;
          end
        endcase
      end else if (state == ST_IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_LAST) begin
        frame_err <= 1'b1;
        err_code  <= ERR_TMO;
        state     <= ST_IDLE;
        tmo_cnt   <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pld_data  = pld_data;
  assign bus.pld_valid = pld_valid;
  assign bus.pld_last  = pld_last;
  assign bus.frame_len = frame_len;
  assign bus.frame_ok  = frame_ok;
  assign bus.frame_err = frame_err;
  assign bus.err_code  = err_code;

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
Sits directly downstream of uart_rx and consumes its rx_data/done_flag byte stream. It delimits command frames of the form HEADER, LEN, LEN payload bytes, CHECKSUM. Payload bytes are forwarded as a valid-qualified stream, and each frame ends with a single-cycle ok or error pulse. An inter-byte timeout recovers the parser when a sender stalls mid-frame.

Parameters:
HEADER, 8'h55, start-of-frame byte value
MAX_LEN, 16, largest legal payload length in bytes (1..255)
TIMEOUT_CYC, 100000, idle clock cycles between bytes that abort a frame (2 ms at 50 MHz)
CNT_W, 17, timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYC

Ports:
sclk_50M    input   1  system clock, 50 MHz
s_rst_n     input   1  asynchronous active-low reset
rx_data     input   8  received byte from uart_rx; valid only when done_flag=1
done_flag   input   1  one-cycle pulse per received byte
pld_data    output  8  forwarded payload byte
pld_valid   output  1  one-cycle pulse; pld_data valid
pld_last    output  1  asserted with pld_valid on the final payload byte
frame_len   output  8  LEN of the current or most recent frame
frame_ok    output  1  one-cycle pulse; checksum matched
frame_err   output  1  one-cycle pulse; frame aborted
err_code    output  2  cause of the most recent frame_err: 1=length, 2=checksum, 3=timeout

Behaviour:
- One clock (sclk_50M); reset asynchronous, active-low (s_rst_n). All outputs are registered.
- Reset values: every output is 0. State=IDLE, byte counter=0, sum=0, timeout counter=0.
- Latency: each output reacts 1 cycle after the done_flag cycle that causes it.
- FSM states: IDLE, LEN, PAYLOAD, CSUM. Only done_flag=1 cycles advance the FSM; rx_data is ignored otherwise.
- IDLE: if rx_data==HEADER, go to LEN. Any other byte is silently discarded and no error is raised.
- LEN:
  - If rx_data is 0 or greater than MAX_LEN: frame_err=1, err_code=1, go to IDLE.
  - Otherwise: latch frame_len=rx_data, sum=rx_data, byte counter=rx_data, go to PAYLOAD.
- PAYLOAD, per byte:
  - pld_data=rx_data, pld_valid=1.
  - sum=sum+rx_data, modulo 256.
  - Decrement the byte counter.
  - On the byte where the counter was 1: pld_last=1, go to CSUM.
- CSUM:
  - If rx_data==sum: frame_ok=1.
  - Otherwise: frame_err=1, err_code=2.
  - Either way, go to IDLE.
- A HEADER-valued byte inside LEN, PAYLOAD or CSUM is treated as ordinary data; there is no resync on HEADER.
- Timeout counter:
  - Cleared on every done_flag and while in IDLE.
  - Increments every cycle otherwise.
  - When the count reaches TIMEOUT_CYC-1 outside IDLE: frame_err=1, err_code=3, go to IDLE, clear the counter.
- Simultaneous timeout terminal count and done_flag: the byte wins. Clear the counter, process the byte, no error.
- err_code and frame_len hold their values until overwritten; only reset clears them.
- frame_ok and frame_err are never asserted in the same cycle.
- Payload bytes already forwarded before an error are not retracted. Downstream logic must discard them on frame_err.
- Reset mid-frame: the parser returns to IDLE immediately, with no pulse on frame_ok or frame_err.
- Back-to-back bytes: done_flag may assert on consecutive cycles; the parser accepts one byte per cycle with no stall.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding: IDLE=0, LEN=1, PAYLOAD=2, CSUM=3.
  - Error-code constants: ERR_LEN=1, ERR_CSUM=2, ERR_TMO=3.
  - The default header constant 8'h55.
- No sub-module is required. The timeout counter is small enough to stay inline.

Test Plan:
- Good frame: bytes 55 03 12 34 AA F3 → pld_valid pulses with 12, 34, AA; pld_last on AA; frame_len=3; frame_ok one cycle after F3; frame_err stays 0.
- Bad checksum: 55 03 12 34 AA 00 → three payload pulses, then frame_err=1 with err_code=2; frame_ok stays 0.
- Illegal length: 55 00, then 55 11 (17 > MAX_LEN) → two frame_err pulses, each with err_code=1; no pld_valid; the parser then accepts 55 01 7E 7F with frame_ok.
- Leading garbage: 00 AA 13 55 01 7E 7F → the first three bytes are ignored; pld_data=7E with pld_last; frame_ok.
- Timeout: 55 02 01, then no done_flag → frame_err with err_code=3 exactly TIMEOUT_CYC cycles after the last done_flag (use TIMEOUT_CYC=50 in simulation). Also a byte arriving on the terminal cycle produces no error.
- Reset mid-frame: 55 04 11 22, assert s_rst_n=0 for 3 cycles, release → all outputs 0 with no pulse; the next frame 55 01 05 06 gives frame_ok.
